// File: rtl/wb_regfile_pkg.sv
// Shared constants, payload types and helpers for the write-back register file.
// Build option: define WB_BYPASS_EN for same-cycle read-during-write forwarding.
package wb_regfile_pkg;

  localparam int unsigned REG_NUM   = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W_DEF = 32;

  localparam logic [DATA_W-1:0] ZERO_WORD    = '0;
  localparam logic [REG_AW-1:0] NOP_REG_ADDR = '0;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } hilo_t;

  // A GPR write only commits when it targets a register other than $0.
  function automatic logic gpr_commit(input logic we, input logic [REG_AW-1:0] waddr);
    return we && (waddr != NOP_REG_ADDR);
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write port, ID read ports, EX HI/LO read port and retire count of wb_regfile.
interface wb_regfile_if #(
  parameter int unsigned CNT_W = wb_regfile_pkg::CNT_W_DEF
) ();

  logic                                 we;
  logic [wb_regfile_pkg::REG_AW-1:0]    waddr;
  logic [wb_regfile_pkg::DATA_W-1:0]    wdata;
  logic                                 whilo;
  logic [wb_regfile_pkg::DATA_W-1:0]    hi_i;
  logic [wb_regfile_pkg::DATA_W-1:0]    lo_i;
  logic                                 re1;
  logic [wb_regfile_pkg::REG_AW-1:0]    raddr1;
  logic [wb_regfile_pkg::DATA_W-1:0]    rdata1;
  logic                                 re2;
  logic [wb_regfile_pkg::REG_AW-1:0]    raddr2;
  logic [wb_regfile_pkg::DATA_W-1:0]    rdata2;
  logic [wb_regfile_pkg::DATA_W-1:0]    hi_o;
  logic [wb_regfile_pkg::DATA_W-1:0]    lo_o;
  logic [CNT_W-1:0]                     retire_cnt;

  modport master (
    output we, waddr, wdata, whilo, hi_i, lo_i, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o, retire_cnt
  );

  modport slave (
    input  we, waddr, wdata, whilo, hi_i, lo_i, re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o, retire_cnt
  );

endinterface

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO register pair; both halves always written together.
// With WB_BYPASS_EN the incoming pair is forwarded to the read port in the write cycle.
module wb_regfile_hilo_reg
  import wb_regfile_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  whilo,
  input  hilo_t wr,
  output hilo_t rd
);

  hilo_t q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (whilo) begin
      q <= wr;
    end
  end

  // Read port is forced to zero while reset is held.
  always_comb begin
    rd = '0;
    if (!rst) begin
      rd = (BYPASS_EN && whilo) ? wr : q;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back sink: 32x32 GPR file with two read ports, HI/LO pair and retire counter.
// Build option: WB_BYPASS_EN forwards same-cycle writes to the read ports.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);

  logic [DATA_W-1:0] gpr [REG_NUM];
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_commit;
  hilo_t             hilo_wr;
  hilo_t             hilo_rd;

  assign wr_commit = gpr_commit(bus.we, bus.waddr);

  // $0 is never written, so it holds its reset value of zero forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        gpr[i] <= ZERO_WORD;
      end
    end else if (wr_commit) begin
      gpr[bus.waddr] <= bus.wdata;
    end
  end

  // One increment per cycle even when a GPR and HI/LO write coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (wr_commit || bus.whilo) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    bus.rdata1 = ZERO_WORD;
    if (!rst && bus.re1 && (bus.raddr1 != NOP_REG_ADDR)) begin
      if (BYPASS_EN && wr_commit && (bus.waddr == bus.raddr1)) begin
        bus.rdata1 = bus.wdata;
      end else begin
        bus.rdata1 = gpr[bus.raddr1];
      end
    end
  end

  always_comb begin
    bus.rdata2 = ZERO_WORD;
    if (!rst && bus.re2 && (bus.raddr2 != NOP_REG_ADDR)) begin
      if (BYPASS_EN && wr_commit && (bus.waddr == bus.raddr2)) begin
        bus.rdata2 = bus.wdata;
      end else begin
        bus.rdata2 = gpr[bus.raddr2];
      end
    end
  end

  assign hilo_wr = '{hi: bus.hi_i, lo: bus.lo_i};

  wb_regfile_hilo_reg u_hilo (
    .clk   (clk),
    .rst   (rst),
    .whilo (bus.whilo),
    .wr    (hilo_wr),
    .rd    (hilo_rd)
  );

  assign bus.hi_o       = hilo_rd.hi;
  assign bus.lo_o       = hilo_rd.lo;
  assign bus.retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed bench for wb_regfile against an array-based reference model.
// A second instance with a 4-bit retire counter exercises counter wrap-around.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmp_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wb_regfile_if #(.CNT_W(32)) bus ();
  wb_regfile_if #(.CNT_W(4))  bus_w ();

  wb_regfile #(.CNT_W(32)) dut   (.clk(clk), .rst(rst), .bus(bus));
  wb_regfile #(.CNT_W(4))  dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  // Reference state: plain array, HI/LO words and a 32-bit commit count.
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  logic [31:0] m_cnt = 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
      m_hi = 32'h0; m_lo = 32'h0; m_cnt = 32'h0;
    end else begin
      if ((bus.we && bus.waddr != 5'd0) || bus.whilo) m_cnt = m_cnt + 32'd1;
      if (bus.we && bus.waddr != 5'd0) m_gpr[bus.waddr] = bus.wdata;
      if (bus.whilo) begin m_hi = bus.hi_i; m_lo = bus.lo_i; end
    end
  end

  function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
    if (rst || !re || a == 5'd0) return 32'h0;
    if (BYPASS_EN && bus.we && bus.waddr != 5'd0 && bus.waddr == a) return bus.wdata;
    return m_gpr[a];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every negedge: compare all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_rdata1", 64'(bus.rdata1), 64'(exp_rd(bus.re1, bus.raddr1)));
      chk("cmp_rdata2", 64'(bus.rdata2), 64'(exp_rd(bus.re2, bus.raddr2)));
      chk("cmp_hi", 64'(bus.hi_o), 64'(rst ? 32'h0 : (BYPASS_EN && bus.whilo) ? bus.hi_i : m_hi));
      chk("cmp_lo", 64'(bus.lo_o), 64'(rst ? 32'h0 : (BYPASS_EN && bus.whilo) ? bus.lo_i : m_lo));
      chk("cmp_cnt", 64'(bus.retire_cnt), 64'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.waddr = 5'd0; bus.wdata = 32'h0;
    bus.whilo = 1'b0; bus.hi_i = 32'h0; bus.lo_i = 32'h0;
    bus.re1 = 1'b0; bus.raddr1 = 5'd0; bus.re2 = 1'b0; bus.raddr2 = 5'd0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
    idle();
    bus_w.we = 1'b0; bus_w.waddr = 5'd0; bus_w.wdata = 32'h0;
    bus_w.whilo = 1'b0; bus_w.hi_i = 32'h0; bus_w.lo_i = 32'h0;
    bus_w.re1 = 1'b0; bus_w.raddr1 = 5'd0; bus_w.re2 = 1'b0; bus_w.raddr2 = 5'd0;
    step();
    cmp_en = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cnt", 64'(bus.retire_cnt), 64'h0);
    chk("reset_hi", 64'(bus.hi_o), 64'h0);

    // Write to $0 is dropped and not counted.
    step(); bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hDEADBEEF;
    step(); idle(); bus.re1 = 1'b1; bus.raddr1 = 5'd0;
    @(negedge clk);
    chk("r0_read", 64'(bus.rdata1), 64'h0);
    chk("r0_cnt", 64'(bus.retire_cnt), 64'h0);

    // Read-during-write on r5.
    step(); bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'h1234_5678;
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    @(negedge clk);
    chk("rdw_same", 64'(bus.rdata1), BYPASS_EN ? 64'h1234_5678 : 64'h0);
    step(); bus.we = 1'b0;
    @(negedge clk);
    chk("rdw_next", 64'(bus.rdata1), 64'h1234_5678);
    chk("rdw_cnt", 64'(bus.retire_cnt), 64'h1);

    // HI/LO write, with read port 1 disabled.
    step(); bus.whilo = 1'b1; bus.hi_i = 32'hAAAA0000; bus.lo_i = 32'h0000BBBB;
    bus.re1 = 1'b0; bus.raddr1 = 5'd5;
    @(negedge clk);
    chk("hi_same", 64'(bus.hi_o), BYPASS_EN ? 64'hAAAA0000 : 64'h0);
    chk("lo_same", 64'(bus.lo_o), BYPASS_EN ? 64'h0000BBBB : 64'h0);
    chk("re1_off", 64'(bus.rdata1), 64'h0);
    step(); idle();
    @(negedge clk);
    chk("hi_next", 64'(bus.hi_o), 64'hAAAA0000);
    chk("lo_next", 64'(bus.lo_o), 64'h0000BBBB);
    chk("hilo_cnt", 64'(bus.retire_cnt), 64'h2);

    // Simultaneous GPR and HI/LO write counts once.
    step(); bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h77;
    bus.whilo = 1'b1; bus.hi_i = 32'h1; bus.lo_i = 32'h2;
    step(); idle();
    @(negedge clk);
    chk("both_cnt", 64'(bus.retire_cnt), 64'h3);

    // Fill r1..r31 with their index and read crossed pairs.
    for (int i = 1; i < 32; i++) begin
      step(); bus.we = 1'b1; bus.waddr = 5'(i); bus.wdata = 32'(i);
    end
    step(); idle();
    @(negedge clk);
    chk("fill_cnt", 64'(bus.retire_cnt), 64'd34);
    for (int i = 0; i < 32; i++) begin
      step(); bus.re1 = 1'b1; bus.re2 = 1'b1; bus.raddr1 = 5'(i); bus.raddr2 = 5'(31 - i);
      @(negedge clk);
      chk("pair_rd1", 64'(bus.rdata1), 64'(i));
      chk("pair_rd2", 64'(bus.rdata2), 64'(31 - i));
    end

    // Random traffic; the negedge comparator does the checking.
    for (int n = 0; n < 3000; n++) begin
      step();
      bus.we     = ($urandom_range(0, 3) != 0);
      bus.waddr  = 5'($urandom_range(0, 31));
      bus.wdata  = $urandom;
      bus.whilo  = ($urandom_range(0, 3) == 0);
      bus.hi_i   = $urandom;
      bus.lo_i   = $urandom;
      bus.re1    = ($urandom_range(0, 7) != 0);
      bus.re2    = ($urandom_range(0, 7) != 0);
      bus.raddr1 = ($urandom_range(0, 2) == 0) ? bus.waddr : 5'($urandom_range(0, 31));
      bus.raddr2 = ($urandom_range(0, 3) == 0) ? bus.raddr1 : 5'($urandom_range(0, 31));
    end

    // Make r31 and HI/LO nonzero, then assert reset mid-cycle.
    step(); idle(); bus.we = 1'b1; bus.waddr = 5'd31; bus.wdata = 32'hCAFE_F00D;
    bus.whilo = 1'b1; bus.hi_i = 32'h5; bus.lo_i = 32'h6;
    step(); idle(); bus.re1 = 1'b1; bus.raddr1 = 5'd31; bus.re2 = 1'b1; bus.raddr2 = 5'd31;
    @(negedge clk);
    chk("pre_rst_rd", 64'(bus.rdata1), 64'hCAFE_F00D);
    step();
    #1 rst = 1'b1;
    #1;
    chk("arst_rd1", 64'(bus.rdata1), 64'h0);
    chk("arst_rd2", 64'(bus.rdata2), 64'h0);
    chk("arst_hi", 64'(bus.hi_o), 64'h0);
    chk("arst_lo", 64'(bus.lo_o), 64'h0);
    chk("arst_cnt", 64'(bus.retire_cnt), 64'h0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rd", 64'(bus.rdata1), 64'h0);
    chk("post_rst_hi", 64'(bus.hi_o), 64'h0);

    // Wrap of the 4-bit counter: 15 commits then one more.
    for (int i = 0; i < 15; i++) begin
      step(); bus_w.we = 1'b1; bus_w.waddr = 5'd7; bus_w.wdata = 32'(i); bus_w.whilo = 1'b1;
    end
    step(); bus_w.we = 1'b0; bus_w.whilo = 1'b0;
    @(negedge clk);
    chk("wrap_max", 64'(bus_w.retire_cnt), 64'hF);
    step(); bus_w.we = 1'b1; bus_w.whilo = 1'b1;
    step(); bus_w.we = 1'b0; bus_w.whilo = 1'b0;
    @(negedge clk);
    chk("wrap_zero", 64'(bus_w.retire_cnt), 64'h0);

    step();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
